// File: rtl/neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_sequencer
//  Description : Sequencer for one fully-connected neural-network layer.
//                For every neuron j it streams x[i] and w[j][i] from
//                synchronous memories into a downstream signed MAC. It then
//                adds the bias, applies ReLU, rescales by an arithmetic right
//                shift, saturates, and writes y[j]. The top-level controller
//                uses a start/busy/done handshake.
//
//  Ports       : clk         rising-edge clock
//                aclr        asynchronous active-high reset
//                start       one-cycle run request (ignored while busy)
//                busy        high in every state except IDLE
//                done        one-cycle pulse after the final y write
//                x_addr      activation memory address (i)
//                x_data      activation read data (1-cycle latency)
//                w_addr      weight memory address (j*N_INPUTS+i)
//                w_data      weight read data (1-cycle latency)
//                b_addr      bias memory address (j)
//                b_data      bias read data (1-cycle latency)
//                mac_dataa   MAC operand A (activation)
//                mac_datab   MAC operand B (weight)
//                mac_clken   MAC clock enable
//                mac_sload   MAC synchronous load (first product of a neuron)
//                mac_result  registered MAC accumulator output
//                y_addr      output activation address
//                y_data      output activation (always >= 0)
//                y_valid     write strobe for y_addr/y_data
//
//  Revision    : 1.0  initial release
// ============================================================================
module neuron_layer_sequencer #(
    parameter int N_INPUTS  = 784,
    parameter int N_NEURONS = 32,
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 8,
    parameter int WIDTH_OUT = 32,
    parameter int SHIFT     = 8,
    parameter int WIDTH_Y   = 8
) (
    input  logic                                              clk,
    input  logic                                              aclr,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              done,
    output logic [$clog2(N_INPUTS)-1:0]                       x_addr,
    input  logic [WIDTH_A-1:0]                                x_data,
    output logic [$clog2(N_INPUTS*N_NEURONS)-1:0]             w_addr,
    input  logic [WIDTH_B-1:0]                                w_data,
    output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] b_addr,
    input  logic [WIDTH_OUT-1:0]                              b_data,
    output logic [WIDTH_A-1:0]                                mac_dataa,
    output logic [WIDTH_B-1:0]                                mac_datab,
    output logic                                              mac_clken,
    output logic                                              mac_sload,
    input  logic [WIDTH_OUT-1:0]                              mac_result,
    output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] y_addr,
    output logic [WIDTH_Y-1:0]                                y_data,
    output logic                                              y_valid
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int c_XW = $clog2(N_INPUTS);
    localparam int c_WW = $clog2(N_INPUTS * N_NEURONS);
    localparam int c_JW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    localparam logic [c_XW-1:0] c_I_LAST = c_XW'(N_INPUTS - 1);
    localparam logic [c_JW-1:0] c_J_LAST = c_JW'(N_NEURONS - 1);
    localparam logic [c_WW-1:0] c_W_STEP = c_WW'(N_INPUTS);

    // Largest positive value representable in the signed WIDTH_Y output,
    // held in the (WIDTH_OUT+1)-bit signed domain of the bias sum.
    localparam logic signed [WIDTH_OUT:0] c_Y_MAX =
        {{(WIDTH_OUT + 2 - WIDTH_Y){1'b0}}, {(WIDTH_Y - 1){1'b1}}};

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ACCUM  = 3'd1;
    localparam logic [2:0] c_ST_DRAIN  = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_XW-1:0]    r_i;        // input index within the current neuron
    logic [c_JW-1:0]    r_j;        // current neuron index
    logic [c_WW-1:0]    r_wbase;    // j*N_INPUTS, kept incrementally
    logic               r_vld;      // read data on x_data/w_data is valid
    logic               r_first;    // valid data belongs to i == 0
    logic [WIDTH_Y-1:0] r_y_data;
    logic [c_JW-1:0]    r_y_addr;

    // ------------------------------------------------------------------
    // Bias, ReLU, rescale and saturate
    // ------------------------------------------------------------------
    // One extra bit keeps the bias addition from wrapping.
    logic signed [WIDTH_OUT:0] w_sum;
    logic signed [WIDTH_OUT:0] w_shift;
    logic signed [WIDTH_OUT:0] w_relu;
    logic [WIDTH_Y-1:0]        w_y_sat;

    always_comb begin
        w_sum   = $signed({mac_result[WIDTH_OUT-1], mac_result})
                + $signed({b_data[WIDTH_OUT-1], b_data});
        w_shift = w_sum >>> SHIFT;
        w_relu  = w_sum[WIDTH_OUT] ? '0 : w_shift;
        w_y_sat = (w_relu > c_Y_MAX) ? c_Y_MAX[WIDTH_Y-1:0]
                                     : w_relu[WIDTH_Y-1:0];
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state  <= c_ST_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_wbase  <= '0;
            r_vld    <= 1'b0;
            r_first  <= 1'b0;
            r_y_data <= '0;
            r_y_addr <= '0;
        end else begin
            // Memories answer one cycle after the address, so the valid
            // flag is simply "an address was issued last cycle".
            r_vld   <= (r_state == c_ST_ACCUM);
            r_first <= (r_state == c_ST_ACCUM) && (r_i == '0);

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_ACCUM;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_wbase <= '0;
                    end
                end

                c_ST_ACCUM: begin
                    if (r_i == c_I_LAST) begin
                        r_i     <= '0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end

                // Last product enters the MAC; b_addr (= j) is already
                // being read so the bias is ready during SETTLE.
                c_ST_DRAIN: begin
                    r_state <= c_ST_SETTLE;
                end

                c_ST_SETTLE: begin
                    r_y_data <= w_y_sat;
                    r_y_addr <= r_j;
                    r_state  <= c_ST_WRITE;
                end

                c_ST_WRITE: begin
                    if (r_j == c_J_LAST) begin
                        r_j     <= '0;
                        r_wbase <= '0;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_wbase <= r_wbase + c_W_STEP;
                        r_state <= c_ST_ACCUM;
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (r_state != c_ST_IDLE);
        done    = (r_state == c_ST_DONE);
        y_valid = (r_state == c_ST_WRITE);
        y_data  = r_y_data;
        y_addr  = r_y_addr;

        x_addr  = r_i;
        w_addr  = r_wbase + c_WW'(r_i);
        b_addr  = r_j;

        // MAC operands are forced to zero outside valid cycles so the MAC
        // only ever sees data that matches an issued address. sload on the
        // first product of every neuron discards stale accumulator content.
        mac_clken = r_vld;
        mac_sload = r_vld & r_first;
        mac_dataa = r_vld ? x_data : '0;
        mac_datab = r_vld ? w_data : '0;
    end

endmodule
`default_nettype wire

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
Controls one fully-connected layer by driving the signed multiply-accumulate stage that sits directly downstream of it.
- For each neuron j, streams activations x[i] and weights w[j][i] from synchronous ROM/RAM into the MAC.
- Then adds the bias, applies ReLU, rescales and saturates, and writes the output activation y[j].
- Start/busy/done handshake to the top-level network controller.

Parameters:
N_INPUTS, 784, activations per neuron (>=2)
N_NEURONS, 32, neurons in layer (>=1)
WIDTH_A, 32, activation width (signed), MAC dataa width
WIDTH_B, 8, weight width (signed), MAC datab width
WIDTH_OUT, 32, MAC accumulator and bias width (signed)
SHIFT, 8, arithmetic right shift applied after ReLU
WIDTH_Y, 8, output activation width (signed; result always >=0)

Ports:
clk  in  1  clock, all logic on rising edge
aclr  in  1  asynchronous active-high reset
start  in  1  one-cycle request to run the layer; ignored while busy
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after final y write
x_addr  out  $clog2(N_INPUTS)  activation memory address
x_data  in  WIDTH_A  activation read data, 1-cycle read latency
w_addr  out  $clog2(N_INPUTS*N_NEURONS)  weight address = j*N_INPUTS+i
w_data  in  WIDTH_B  weight read data, 1-cycle latency
b_addr  out  $clog2(N_NEURONS)  bias address = j
b_data  in  WIDTH_OUT  bias read data, 1-cycle latency
mac_dataa  out  WIDTH_A  to MAC dataa
mac_datab  out  WIDTH_B  to MAC datab
mac_clken  out  1  to MAC clken
mac_sload  out  1  to MAC sload (clears accumulator for first product)
mac_result  in  WIDTH_OUT  MAC adder_out (registered in MAC)
y_addr  out  $clog2(N_NEURONS)  output activation address
y_data  out  WIDTH_Y  output activation
y_valid  out  1  write strobe for y_data/y_addr

Behaviour:
- Reset: aclr asserted at any time forces IDLE immediately; busy, done, y_valid, mac_clken and mac_sload go to 0; all addresses, y_data, mac_dataa and mac_datab go to 0; counters i and j are cleared.
- States: IDLE, ACCUM, DRAIN, SETTLE, WRITE, DONE.
- IDLE: start=1 -> ACCUM with i=0, j=0.
- ACCUM, N_INPUTS cycles: x_addr=i, w_addr=j*N_INPUTS+i, b_addr=j; i increments each cycle; after i=N_INPUTS-1 -> DRAIN.
- Data valid pipeline: a 1-cycle delayed valid flag marks when x_data/w_data correspond to an issued address. While it is set: mac_dataa=x_data, mac_datab=w_data (combinational), mac_clken=1, and mac_sload=1 only for i=0's data. Otherwise mac_clken=0, mac_sload=0, and data ports are 0.
- DRAIN, 1 cycle: the last product is presented to the MAC; no new address is issued.
- SETTLE, 1 cycle: mac_result holds the full dot product.
  - s = mac_result + b_data, computed in WIDTH_OUT+1 bits, no wrap.
  - r = (s<0) ? 0 : s >>> SHIFT.
  - y_data is registered as min(r, 2^(WIDTH_Y-1)-1); y_addr=j is registered.
- WRITE, 1 cycle: y_valid=1; then j increments.
  - If j was N_NEURONS-1 -> DONE; else -> ACCUM with i=0.
- DONE, 1 cycle: done=1, busy=1 -> IDLE.
- y_data/y_addr hold their last values until the next WRITE.
- Timing: start sampled at edge k; ACCUM first cycle is k+1; each neuron takes N_INPUTS+3 cycles; done is high in cycle k+1+N_NEURONS*(N_INPUTS+3).
- start during any non-IDLE state is ignored; there is no queuing.
- Every neuron's first product uses mac_sload, so stale MAC contents, including after reset mid-layer, never leak into results.

Test Plan (N_INPUTS=4, N_NEURONS=2, SHIFT=2, WIDTH_Y=8, memory models with 1-cycle latency, MAC instantiated downstream):
1. x={1,2,3,4}; w0={1,1,1,1}, w1={-1,-1,-1,-1}; biases 0 -> y[0]=2 (10>>>2), y[1]=0 (ReLU); y_valid pulses with y_addr 0 then 1.
2. x all 1000, w0 all 127, bias 0 -> 508000>>>2=127000 -> y[0]=127 (saturated).
3. x={1,2,3,4}, w0 all 1; bias -12 -> y[0]=0; bias +6 -> y[0]=4 (16>>>2).
4. start at edge k -> busy from k+1; done exactly in cycle k+15; a second start at k+5 is ignored, giving exactly 2 y_valid pulses and 1 done.
5. aclr asserted mid-ACCUM of neuron 1 -> all outputs 0 that same cycle, state IDLE; a fresh start reproduces test 1 results exactly.
6. Protocol check across neurons: mac_sload=1 exactly once per neuron, coinciding with the first mac_clken cycle; mac_clken is high exactly N_INPUTS cycles per neuron.
